// File: rtl/ntt_mem_sched.sv
`default_nettype none
// ============================================================================
// Module   : ntt_mem_sched
// Brief    : BRAM address/twiddle sequencer for an in-place radix-2 CT NTT.
// Revision : 1.0
// ============================================================================
module ntt_mem_sched #(
  parameter int DATA_WIDTH = 12,
  parameter int ADW        = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  host_we_i,
  input  logic [ADW-1:0]        host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_din_i,
  output logic                  host_drop_o,
  output logic                  ram_we_a_o,
  output logic                  ram_we_b_o,
  output logic [ADW-1:0]        ram_addr_a_o,
  output logic [ADW-1:0]        ram_addr_b_o,
  output logic [DATA_WIDTH-1:0] ram_din_a_o,
  output logic [DATA_WIDTH-1:0] ram_din_b_o,
  output logic                  bf_valid_o,
  output logic [ADW-1:0]        tw_idx_o,
  input  logic                  bf_done_i,
  input  logic [DATA_WIDTH-1:0] bf_a_i,
  input  logic [DATA_WIDTH-1:0] bf_b_i
);

  localparam int             SW         = $clog2(ADW + 1);
  localparam logic [SW-1:0]  LAST_STAGE = SW'(ADW - 1);
  localparam logic [SW-1:0]  STAGE_ONE  = SW'(1);
  localparam logic [ADW-2:0] BF_ONE     = (ADW-1)'(1);
  localparam logic [ADW-1:0] ADDR_ONE   = ADW'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_DAT  = 3'd2,
    S_WAIT = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [ADW-2:0]        bf_q, bf_d;
  logic [DATA_WIDTH-1:0] res_a_q, res_a_d;
  logic [DATA_WIDTH-1:0] res_b_q, res_b_d;

  logic [SW-1:0]  w_shift;
  logic [ADW-1:0] w_bf_ext;
  logic [ADW-1:0] w_len;
  logic [ADW-1:0] w_addr_j;
  logic [ADW-1:0] w_tw_idx;
  logic           w_busy;

  // j is bf with a zero inserted at bit (ADW-1-stage); its partner sits len above.
  always_comb begin
    w_shift  = LAST_STAGE - stage_q;
    w_bf_ext = {1'b0, bf_q};
    w_len    = ADDR_ONE << w_shift;
    w_addr_j = (((w_bf_ext >> w_shift) << w_shift) << 1) | (w_bf_ext & (w_len - ADDR_ONE));
    w_tw_idx = (ADDR_ONE << stage_q) + (w_bf_ext >> w_shift);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      bf_q    <= '0;
      res_a_q <= '0;
      res_b_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bf_q    <= bf_d;
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bf_d    = bf_q;
    res_a_d = res_a_q;
    res_b_d = res_b_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RD;
          stage_d = '0;
          bf_d    = '0;
        end
      end
      S_RD:  state_d = S_DAT;
      S_DAT: state_d = S_WAIT;
      S_WAIT: begin
        if (bf_done_i) begin
          res_a_d = bf_a_i;
          res_b_d = bf_b_i;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (bf_q != '1) begin
          bf_d    = bf_q + BF_ONE;
          state_d = S_RD;
        end else if (stage_q != LAST_STAGE) begin
          bf_d    = '0;
          stage_d = stage_q + STAGE_ONE;
          state_d = S_RD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write enables are masked by rst_i so an aborting reset never lands a write.
  always_comb begin
    w_busy       = (state_q != S_IDLE);
    busy_o       = w_busy;
    done_o       = (state_q == S_DONE);
    bf_valid_o   = (state_q == S_DAT);
    host_drop_o  = host_we_i & w_busy;
    ram_we_a_o   = 1'b0;
    ram_we_b_o   = 1'b0;
    ram_addr_a_o = host_addr_i;
    ram_addr_b_o = '0;
    ram_din_a_o  = host_din_i;
    ram_din_b_o  = '0;
    tw_idx_o     = '0;
    if (state_q == S_IDLE) begin
      ram_we_a_o = host_we_i & ~rst_i;
    end else if (state_q != S_DONE) begin
      ram_addr_a_o = w_addr_j;
      ram_addr_b_o = w_addr_j | w_len;
      ram_din_a_o  = res_a_q;
      ram_din_b_o  = res_b_q;
      tw_idx_o     = w_tw_idx;
      if (state_q == S_WR) begin
        ram_we_a_o = ~rst_i;
        ram_we_b_o = ~rst_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ntt_mem_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_mem_sched
// Brief    : Self-checking bench with BRAM model and butterfly responder.
// Revision : 1.0
// ============================================================================
module tb_ntt_mem_sched;

  localparam int DW  = 12;
  localparam int ADW = 5;
  localparam int N   = 32;
  localparam int NBF = 80;
  localparam int Q   = 3329;

  logic           clk = 1'b0;
  logic           rst_i, start_i, host_we_i, bf_done_i;
  logic [ADW-1:0] host_addr_i;
  logic [DW-1:0]  host_din_i, bf_a_i, bf_b_i;
  logic           busy_o, done_o, host_drop_o, ram_we_a_o, ram_we_b_o, bf_valid_o;
  logic [ADW-1:0] ram_addr_a_o, ram_addr_b_o, tw_idx_o;
  logic [DW-1:0]  ram_din_a_o, ram_din_b_o;

  always #5 clk = ~clk;

  ntt_mem_sched #(.DATA_WIDTH(DW), .ADW(ADW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_din_i(host_din_i),
    .host_drop_o(host_drop_o), .ram_we_a_o(ram_we_a_o), .ram_we_b_o(ram_we_b_o),
    .ram_addr_a_o(ram_addr_a_o), .ram_addr_b_o(ram_addr_b_o),
    .ram_din_a_o(ram_din_a_o), .ram_din_b_o(ram_din_b_o), .bf_valid_o(bf_valid_o),
    .tw_idx_o(tw_idx_o), .bf_done_i(bf_done_i), .bf_a_i(bf_a_i), .bf_b_i(bf_b_i)
  );

  // True-dual-port BRAM, one-cycle read latency
  logic [DW-1:0] mem [N];
  logic [DW-1:0] dout_a, dout_b;
  always @(posedge clk) begin
    if (ram_we_a_o) mem[ram_addr_a_o] <= ram_din_a_o;
    if (ram_we_b_o) mem[ram_addr_b_o] <= ram_din_b_o;
    dout_a <= mem[ram_addr_a_o];
    dout_b <= mem[ram_addr_b_o];
  end

  int checks = 0;
  int errors = 0;
  int zeta  [N];
  int exp_a [NBF];
  int exp_b [NBF];
  int exp_k [NBF];
  int loaded[N];
  int bf_mode, bf_stall, stall_sum;
  bit bf_rand, bf_tie;

  // mode 2: Kyber-style CT butterfly mod Q; otherwise a+1, b+2
  function automatic void bfly(input int mode, input int k, input int a, input int b,
                               output int ra, output int rb);
    int t;
    if (mode == 2) begin
      t  = (zeta[k] * b) % Q;
      ra = (a + t) % Q;
      rb = (a - t + Q) % Q;
    end else begin
      ra = (a + 1) % 4096;
      rb = (b + 2) % 4096;
    end
  endfunction

  // Reference schedule: textbook forward CT loop nest
  task automatic build_schedule();
    int k, n, z;
    k = 1; n = 0; z = 1;
    for (int len = N / 2; len >= 1; len = len / 2) begin
      for (int st = 0; st < N; st = st + 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          exp_a[n] = j; exp_b[n] = j + len; exp_k[n] = k; n++;
        end
        k++;
      end
    end
    for (int i = 0; i < N; i++) begin
      zeta[i] = z;
      z = (z * 17) % Q;
    end
  endtask

  // Butterfly unit: latches operands on bf_valid_o, answers after stall cycles of WAIT
  initial begin
    int pend, cnt, ra, rb;
    bit dr;
    pend = 0; cnt = 0; dr = 1'b0;
    bf_done_i = 1'b0; bf_a_i = '0; bf_b_i = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        pend = 0; dr = 1'b0;
      end else if (bf_valid_o) begin
        bfly(bf_mode, int'(tw_idx_o), int'(dout_a), int'(dout_b), ra, rb);
        bf_a_i = DW'(ra); bf_b_i = DW'(rb);
        cnt = bf_rand ? int'($urandom_range(3, 0)) : bf_stall;
        stall_sum += cnt;
        pend = 1; dr = 1'b0;
      end else if (pend != 0) begin
        if (dr) begin dr = 1'b0; pend = 0; end
        else if (cnt == 0) dr = 1'b1;
        else cnt--;
      end
      bf_done_i = bf_tie | dr;
    end
  end

  task automatic load_random(input int limit);
    int v;
    for (int i = 0; i < N; i++) begin
      v = int'($urandom_range(limit - 1, 0));
      loaded[i] = v;
      host_we_i = 1'b1; host_addr_i = ADW'(i); host_din_i = DW'(v);
      @(negedge clk);
    end
    host_we_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_transform(input string tag, input int mode, input int stall,
                               input bit rnd, input bit tie);
    int g[N];
    int cyc, idx, ra, rb, exp_cyc;
    for (int i = 0; i < N; i++) g[i] = int'(mem[i]);
    bf_mode = mode; bf_stall = stall; bf_rand = rnd; bf_tie = tie; stall_sum = 0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; cyc = 1; idx = 0;
    while (!done_o && cyc < 2000) begin
      if (ram_we_a_o || ram_we_b_o) begin
        if (idx < NBF) begin
          bfly(mode, exp_k[idx], g[exp_a[idx]], g[exp_b[idx]], ra, rb);
          checks++;
          if ({ram_we_a_o, ram_we_b_o, ram_addr_a_o, ram_addr_b_o, tw_idx_o, ram_din_a_o, ram_din_b_o}
              !== {2'b11, ADW'(exp_a[idx]), ADW'(exp_b[idx]), ADW'(exp_k[idx]), DW'(ra), DW'(rb)}) begin
            errors++;
            $display("FAIL %s_wr%0d got we=%b%b a=%0d b=%0d k=%0d da=%0d db=%0d want a=%0d b=%0d k=%0d da=%0d db=%0d",
                     tag, idx, ram_we_a_o, ram_we_b_o, ram_addr_a_o, ram_addr_b_o, tw_idx_o,
                     ram_din_a_o, ram_din_b_o, exp_a[idx], exp_b[idx], exp_k[idx], ra, rb);
          end
          g[exp_a[idx]] = ra; g[exp_b[idx]] = rb;
        end
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    exp_cyc = 1 + 4 * NBF + stall_sum;
    checks++;
    if (cyc != exp_cyc || idx != NBF) begin
      errors++;
      $display("FAIL %s_timing got done_at=%0d writes=%0d want done_at=%0d writes=%0d", tag, cyc, idx, exp_cyc, NBF);
    end
    checks++;
    if ({done_o, busy_o, ram_we_a_o, ram_we_b_o, bf_valid_o, tw_idx_o} !== {5'b11000, ADW'(0)}) begin
      errors++;
      $display("FAIL %s_done_cycle got done=%b busy=%b we=%b%b bfv=%b k=%0d want done=1 busy=1 we=00 bfv=0 k=0",
               tag, done_o, busy_o, ram_we_a_o, ram_we_b_o, bf_valid_o, tw_idx_o);
    end
    @(negedge clk);
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++;
      $display("FAIL %s_after_done got busy=%b done=%b want 0 0", tag, busy_o, done_o);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[i] !== DW'(g[i])) begin
        errors++;
        $display("FAIL %s_image[%0d] got %0d want %0d", tag, i, mem[i], g[i]);
      end
    end
    bf_tie = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; host_we_i = 1'b1; host_addr_i = 5'd5; host_din_i = 12'd7; start_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, done_o, bf_valid_o, host_drop_o, ram_we_a_o, ram_we_b_o, tw_idx_o} !== {6'b0, ADW'(0)}) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b bfv=%b drop=%b we=%b%b k=%0d want all 0",
               busy_o, done_o, bf_valid_o, host_drop_o, ram_we_a_o, ram_we_b_o, tw_idx_o);
    end
    rst_i = 1'b0; host_we_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_host_load();
    for (int i = 0; i < N; i++) begin
      host_we_i = 1'b1; host_addr_i = ADW'(i); host_din_i = DW'(i);
      #1;
      checks++;
      if ({ram_we_a_o, ram_addr_a_o, ram_din_a_o, ram_we_b_o, ram_addr_b_o, ram_din_b_o, host_drop_o}
          !== {1'b1, ADW'(i), DW'(i), 1'b0, ADW'(0), DW'(0), 1'b0}) begin
        errors++;
        $display("FAIL host_write%0d got we=%b%b a=%0d da=%0d b=%0d db=%0d drop=%b want we=10 a=%0d da=%0d b=0 db=0 drop=0",
                 i, ram_we_a_o, ram_we_b_o, ram_addr_a_o, ram_din_a_o, ram_addr_b_o, ram_din_b_o, host_drop_o, i, i);
      end
      @(negedge clk);
    end
    host_we_i = 1'b0;
    for (int i = 0; i < N; i++) begin
      host_addr_i = ADW'(i);
      @(negedge clk);
      checks++;
      if (dout_a !== DW'(i)) begin
        errors++;
        $display("FAIL host_read%0d got %0d want %0d", i, dout_a, i);
      end
    end
  endtask

  task automatic test_addr_sequence();
    load_random(4096);
    run_transform("seq", 1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_writeback();
    load_random(4096);
    run_transform("wb", 1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_end_to_end();
    int sw[N];
    int k, z, t;
    load_random(Q);
    for (int i = 0; i < N; i++) sw[i] = loaded[i];
    run_transform("e2e", 2, 0, 1'b1, 1'b0);
    k = 1;
    for (int len = N / 2; len >= 1; len = len / 2) begin
      for (int st = 0; st < N; st = st + 2 * len) begin
        z = zeta[k]; k++;
        for (int j = st; j < st + len; j++) begin
          t = (z * sw[j + len]) % Q;
          sw[j + len] = (sw[j] - t + Q) % Q;
          sw[j] = (sw[j] + t) % Q;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[i] !== DW'(sw[i])) begin
        errors++;
        $display("FAIL e2e_ntt[%0d] got %0d want %0d", i, mem[i], sw[i]);
      end
    end
  endtask

  task automatic test_contention();
    int g[N];
    int cyc, bad_drop, dones;
    load_random(4096);
    for (int i = 0; i < N; i++) g[i] = loaded[i];
    for (int n = 0; n < NBF; n++) begin
      g[exp_a[n]] = (g[exp_a[n]] + 1) % 4096;
      g[exp_b[n]] = (g[exp_b[n]] + 2) % 4096;
    end
    bf_mode = 1; bf_stall = 0; bf_rand = 1'b0; bf_tie = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    cyc = 1; bad_drop = 0; dones = 0;
    while (!done_o && cyc < 2000) begin
      host_we_i = 1'b1; host_addr_i = ADW'($urandom); host_din_i = DW'($urandom);
      #1;
      if (host_drop_o !== 1'b1) bad_drop++;
      @(negedge clk);
      cyc++;
    end
    host_we_i = 1'b1;
    #1;
    if (host_drop_o !== 1'b1) bad_drop++;
    checks++;
    if ({done_o, ram_we_a_o} !== 2'b10) begin
      errors++;
      $display("FAIL cont_done_we got done=%b we_a=%b want done=1 we_a=0", done_o, ram_we_a_o);
    end
    start_i = 1'b0; host_we_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    checks++;
    if (bad_drop != 0 || dones != 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL cont_handshake got drop_misses=%0d done_pulses=%0d busy=%b want 0 1 0", bad_drop, dones, busy_o);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[i] !== DW'(g[i])) begin
        errors++;
        $display("FAIL cont_image[%0d] got %0d want %0d", i, mem[i], g[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] snap [N];
    int wr, cyc;
    load_random(4096);
    bf_mode = 1; bf_stall = 3; bf_rand = 1'b0; bf_tie = 1'b0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; wr = 0; cyc = 0;
    while (!(wr == 32 && bf_valid_o) && cyc < 2000) begin
      if (ram_we_a_o) wr++;
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if ({busy_o, bf_valid_o, ram_we_a_o, tw_idx_o} !== {3'b100, ADW'(exp_k[32])}) begin
      errors++;
      $display("FAIL rstmid_wait got busy=%b bfv=%b we=%b k=%0d want busy=1 bfv=0 we=0 k=%0d",
               busy_o, bf_valid_o, ram_we_a_o, tw_idx_o, exp_k[32]);
    end
    for (int i = 0; i < N; i++) snap[i] = mem[i];
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, bf_valid_o, ram_we_a_o, ram_we_b_o, tw_idx_o} !== {5'b0, ADW'(0)}) begin
      errors++;
      $display("FAIL rstmid_idle got busy=%b done=%b bfv=%b we=%b%b k=%0d want all 0",
               busy_o, done_o, bf_valid_o, ram_we_a_o, ram_we_b_o, tw_idx_o);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem[i] !== snap[i]) begin
        errors++;
        $display("FAIL rstmid_nowrite[%0d] got %0d want %0d", i, mem[i], snap[i]);
      end
    end
    run_transform("rerun", 1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0; host_din_i = '0;
    bf_mode = 1; bf_stall = 0; bf_rand = 1'b0; bf_tie = 1'b0; stall_sum = 0;
    build_schedule();
    @(negedge clk);
    test_reset();
    test_host_load();
    test_addr_sequence();
    test_writeback();
    test_end_to_end();
    test_contention();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_mem_sched.md
Name: ntt_mem_sched

Overview:
- Sequencer for the 32-entry, 12-bit true-dual-port coefficient BRAM used by the in-place radix-2 forward NTT.
- Owns both BRAM ports during a transform. It generates Cooley-Tukey butterfly address pairs and twiddle indices, and handshakes with an external butterfly unit.
- When idle, it passes a host load/unload port through to the BRAM.
- Sits between the host/control logic, the butterfly datapath and the BRAM.

Parameters:
- DATA_WIDTH, 12, coefficient width.
- ADW, 5, BRAM address width. N = 2^ADW points, ADW stages, 2^(ADW-1) butterflies per stage.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  begin transform; sampled only in IDLE.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the transform completes.
- host_we_i  in  1  host write enable; routed to BRAM port A in IDLE.
- host_addr_i  in  ADW  host address; routed to port A in IDLE.
- host_din_i  in  DATA_WIDTH  host write data; routed to port A in IDLE.
- host_drop_o  out  1  pulses when host_we_i=1 while busy_o=1; that write is discarded.
- ram_we_a_o, ram_we_b_o  out  1  BRAM write enables.
- ram_addr_a_o, ram_addr_b_o  out  ADW  BRAM addresses.
- ram_din_a_o, ram_din_b_o  out  DATA_WIDTH  BRAM write data.
- bf_valid_o  out  1  one-cycle pulse: BRAM dout_a/dout_b hold the operand pair now.
- tw_idx_o  out  ADW  zeta index k for the current butterfly; stable from RD through WR.
- bf_done_i  in  1  butterfly unit has results on bf_a_i/bf_b_i.
- bf_a_i, bf_b_i  in  DATA_WIDTH  butterfly results for addr_a and addr_b.

Behaviour:
- Reset: state=IDLE, stage=0, bf=0; result registers=0; busy_o, done_o, bf_valid_o, host_drop_o=0.
- Reset mid-transform aborts immediately. BRAM contents are left partially updated; no write occurs in the reset cycle.
- States: IDLE, RD, DAT, WAIT, WR, DONE. RAM outputs are decoded from current state and counters, with no extra register.
- IDLE:
  - port A = host signals.
  - port B: we=0, addr=0, din=0.
  - start_i=1 -> RD with stage=0, bf=0.
- RD:
  - addr_a=j, addr_b=j+len, both we=0.
  - next state DAT.
  - BRAM has 1-cycle read latency.
- DAT:
  - bf_valid_o=1; addresses held; we=0.
  - next state WAIT.
- WAIT:
  - addresses held; we=0.
  - when bf_done_i=1, capture bf_a_i/bf_b_i into result registers and go to WR; otherwise stay.
  - bf_done_i is ignored outside WAIT.
  - No timeout.
- WR:
  - we_a=we_b=1, same addresses, din from result registers.
  - If bf is not last in stage: bf++, next RD.
  - Else if stage is not last: bf=0, stage++, next RD.
  - Else next DONE.
- DONE:
  - done_o=1 for this one cycle; port outputs as in IDLE but with we_a forced 0.
  - next state IDLE.
  - start_i in DONE is ignored.
- Address math, stage s in 0..ADW-1:
  - len = 2^(ADW-1-s).
  - j = bf with a 0 bit inserted at bit position (ADW-1-s). Equivalently j = (bf/len)*2*len + (bf mod len).
  - addr_b = j | len.
- Twiddle index: tw_idx_o = 2^s + (bf >> (ADW-1-s)), i.e. k runs 1..N-1 in order (forward CT order). tw_idx_o=0 in IDLE/DONE.
- host_drop_o is combinational: host_we_i & busy_o.
- Timing with zero-wait butterfly (bf_done_i high on first WAIT cycle): 4 cycles per butterfly. For N=32 that is 80 butterflies = 320 cycles from first RD to last WR. done_o is asserted 321 cycles after the start_i cycle.
- Port A and port B addresses always differ by len ≥ 1, so there is never a same-address dual write.

Test Plan:
- Host load: IDLE, write addr 0..31 with values 0..31, read back -> port A reflects host signals each cycle; ram_we_b_o=0 throughout.
- Address/twiddle sequence: start, bf_done_i tied 1.
  - Stage 0 pairs are (0,16),(1,17)…(15,31), k=1.
  - Stage 1 pairs are (0,8)…(7,15) with k=2, then (16,24)…(23,31) with k=3.
  - Stage 4 pairs are (0,1),(2,3)… with k=16..31.
  - done_o pulses exactly 321 cycles after start.
- Write-back data: butterfly model returns a+1, b+2 with 3-cycle WAIT stall -> each WR shows captured values; total time 80*7+1 cycles; golden model compares final BRAM image.
- End-to-end: load a known polynomial, run against a Kyber-style mod-3329 butterfly model -> BRAM matches the software forward NTT.
- Contention: host_we_i=1 and start_i=1 while busy -> host_drop_o=1 each cycle, no host write lands, second start ignored, single done_o.
- Reset mid-operation: assert rst_i during WAIT of stage 2 -> next cycle IDLE, busy_o=0, no write, tw_idx_o=0; new start then runs a full 321-cycle transform.
